// File: rtl/addsel_pipe.sv
// =============================================================================
// Module   : addsel_pipe
// Function : Two-stage valid/ready pipeline computing (a + CONST) and returning
//            either half of the SUMW-bit sum. Optional overflow flag is
//            enabled by defining ADDSEL_OVF_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module addsel_pipe #(
   parameter int WIDTH  = 3,
   parameter int OWIDTH = 2,
   parameter int CONST  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic              sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OWIDTH-1:0] out
`ifdef ADDSEL_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int SUMW = 2 * OWIDTH;

   generate
      if ((OWIDTH < 1) || (WIDTH > SUMW) || (CONST < 0) ||
          (CONST > (2 ** SUMW) - 1)) begin : g_bad_cfg
         $error("addsel_pipe: illegal WIDTH/OWIDTH/CONST configuration");
      end
   endgenerate

   logic [SUMW-1:0]   w_sum;
   logic              w_s2_load;
   logic              w_s1_adv;

   logic              s1_valid_q, s1_valid_d;
   logic [SUMW-1:0]   s1_sum_q,   s1_sum_d;
   logic              s1_sel_q,   s1_sel_d;
   logic              s2_valid_q, s2_valid_d;
   logic [OWIDTH-1:0] out_q,      out_d;

`ifdef ADDSEL_OVF_EN
   logic [SUMW:0]     w_full;
   logic              s1_carry_q, s1_carry_d;
   logic              ovf_q,      ovf_d;

   assign w_full = (SUMW+1)'(a) + (SUMW+1)'(CONST);
   assign w_sum  = w_full[SUMW-1:0];
   assign ovf    = ovf_q;
`else
   // Truncation at SUMW bits is identical to taking the low bits of the full sum.
   assign w_sum  = SUMW'(a) + SUMW'(CONST);
`endif

   assign w_s2_load = !s2_valid_q || out_ready;
   assign w_s1_adv  = !s1_valid_q || w_s2_load;
   assign in_ready  = w_s1_adv;
   assign out_valid = s2_valid_q;
   assign out       = out_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sum_d   = s1_sum_q;
      s1_sel_d   = s1_sel_q;
      s2_valid_d = s2_valid_q;
      out_d      = out_q;
`ifdef ADDSEL_OVF_EN
      s1_carry_d = s1_carry_q;
      ovf_d      = ovf_q;
`endif
      if (w_s2_load) begin
         s2_valid_d = s1_valid_q;
         // An empty S1 leaves the last delivered result visible on out.
         if (s1_valid_q) begin
            out_d = s1_sel_q ? s1_sum_q[OWIDTH-1:0] : s1_sum_q[SUMW-1:OWIDTH];
`ifdef ADDSEL_OVF_EN
            ovf_d = s1_carry_q;
`endif
         end
      end
      if (w_s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_sum_d = w_sum;
            s1_sel_d = sel;
`ifdef ADDSEL_OVF_EN
            s1_carry_d = w_full[SUMW];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_sel_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         out_q      <= '0;
`ifdef ADDSEL_OVF_EN
         s1_carry_q <= 1'b0;
         ovf_q      <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sum_q   <= s1_sum_d;
         s1_sel_q   <= s1_sel_d;
         s2_valid_q <= s2_valid_d;
         out_q      <= out_d;
`ifdef ADDSEL_OVF_EN
         s1_carry_q <= s1_carry_d;
         ovf_q      <= ovf_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_addsel_pipe.sv
// =============================================================================
// Module   : tb_addsel_pipe
// Function : Directed bench for addsel_pipe (default CONST=3 and CONST=12
//            instances); ovf checks are active when ADDSEL_OVF_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_addsel_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] a;
   logic       sel;
   logic       out_ready;

   logic       in_ready0, out_valid0;
   logic [1:0] out0;
   logic       in_ready1, out_valid1;
   logic [1:0] out1;
`ifdef ADDSEL_OVF_EN
   logic       ovf0, ovf1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   addsel_pipe #(.WIDTH(3), .OWIDTH(2), .CONST(3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .a         (a),
      .sel       (sel),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .out       (out0)
`ifdef ADDSEL_OVF_EN
      ,
      .ovf       (ovf0)
`endif
   );

   addsel_pipe #(.WIDTH(3), .OWIDTH(2), .CONST(12)) u_dut12 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .a         (a),
      .sel       (sel),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .out       (out1)
`ifdef ADDSEL_OVF_EN
      ,
      .ovf       (ovf1)
`endif
   );

   typedef struct {
      logic [2:0] a;
      logic       sel;
      logic [1:0] exp0;
      logic [1:0] exp12;
      logic       ovf12;
   } vec_t;

   localparam int N = 10;
   vec_t vec [N];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] bp_exp [3];
   int rx;

   initial begin
      vec[0] = '{3'd5, 1'b0, 2'b10, 2'b00, 1'b1};
      vec[1] = '{3'd5, 1'b1, 2'b00, 2'b01, 1'b1};
      vec[2] = '{3'd7, 1'b1, 2'b10, 2'b11, 1'b1};
      vec[3] = '{3'd2, 1'b0, 2'b01, 2'b11, 1'b0};
      vec[4] = '{3'd0, 1'b1, 2'b11, 2'b00, 1'b0};
      vec[5] = '{3'd0, 1'b0, 2'b00, 2'b11, 1'b0};
      vec[6] = '{3'd6, 1'b0, 2'b10, 2'b00, 1'b1};
      vec[7] = '{3'd3, 1'b1, 2'b10, 2'b11, 1'b0};
      vec[8] = '{3'd4, 1'b0, 2'b01, 2'b00, 1'b1};
      vec[9] = '{3'd1, 1'b1, 2'b00, 2'b01, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      sel       = 1'b0;
      out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_out", out0, 0);
`ifdef ADDSEL_OVF_EN
      chk("rst_ovf", ovf1, 0);
`endif
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready0, 1);
      tick();

      // Single beat: 2-cycle latency, one-cycle out_valid pulse, out holds
      in_valid = 1'b1; a = 3'd5; sel = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("lat_early_valid", out_valid0, 0);
      tick();
      chk("lat_valid", out_valid0, 1);
      chk("lat_out", out0, 2'b10);
      tick();
      chk("lat_pulse_end", out_valid0, 0);
      chk("lat_out_hold", out0, 2'b10);

      // Back-to-back table stream, full throughput
      for (int i = 0; i <= N; i++) begin
         if (i < N) begin
            in_valid = 1'b1; a = vec[i].a; sel = vec[i].sel;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (i < N) chk("tbl_in_ready", in_ready0, 1);
         tick();
         if (i >= 1) begin
            chk($sformatf("tbl_valid[%0d]", i-1), out_valid0, 1);
            chk($sformatf("tbl_out[%0d]", i-1), out0, vec[i-1].exp0);
            chk($sformatf("tbl_valid12[%0d]", i-1), out_valid1, 1);
            chk($sformatf("tbl_out12[%0d]", i-1), out1, vec[i-1].exp12);
`ifdef ADDSEL_OVF_EN
            chk($sformatf("tbl_ovf12[%0d]", i-1), ovf1, vec[i-1].ovf12);
            chk($sformatf("tbl_ovf[%0d]", i-1), ovf0, 0);
`endif
         end
      end
      tick();
      chk("tbl_drain", out_valid0, 0);

      // Backpressure: three beats, out_ready low for four cycles
      bp_exp[0] = 2'b10;  // a=5 sel=0
      bp_exp[1] = 2'b00;  // a=5 sel=1
      bp_exp[2] = 2'b01;  // a=2 sel=0
      begin
         int p;
         p  = 0;
         rx = 0;
         for (int c = 0; c < 20 && rx < 3; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (p < 3);
            case (p)
               0:       begin a = 3'd5; sel = 1'b0; end
               1:       begin a = 3'd5; sel = 1'b1; end
               default: begin a = 3'd2; sel = 1'b0; end
            endcase
            #1;
            if (c >= 2 && c <= 5) chk("bp_in_ready_low", in_ready0, 0);
            if (out_valid0 && rx < 3) begin
               chk($sformatf("bp_out[%0d]", rx), out0, bp_exp[rx]);
               if (out_ready) rx++;
            end
            if (in_valid && in_ready0) p++;
            tick();
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         chk("bp_delivered", rx, 3);
         tick();
         chk("bp_no_extra", out_valid0, 0);
      end

      // Reset with two beats in flight
      in_valid = 1'b1; a = 3'd7; sel = 1'b1;
      tick();
      a = 3'd6; sel = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("mr_pre_valid", out_valid0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_async_valid", out_valid0, 0);
      chk("mr_async_out", out0, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("mr_in_ready", in_ready0, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mr_no_stale", out_valid0, 0);
      end
      in_valid = 1'b1; a = 3'd0; sel = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("mr_first_valid", out_valid0, 1);
      chk("mr_first_out", out0, 2'b11);
      tick();
      chk("mr_first_end", out_valid0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/addsel_pipe.md
ADDSEL_PIPE -- requirements
Module: addsel_pipe

Interface
REQ-001 Parameter: WIDTH, default 3, operand width of a.
REQ-002 Parameter: OWIDTH, default 2, result width; internal sum width SUMW = 2*OWIDTH.
REQ-003 Parameter: CONST, default 3, unsigned addend; legal range 0 .. 2^SUMW-1.
REQ-004 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: in_valid  input  1  input beat offered.
REQ-007 Port: in_ready  output  1  block accepts the input beat this cycle.
REQ-008 Port: a  input  WIDTH  unsigned operand.
REQ-009 Port: sel  input  1  half select: 1 = low half of sum, 0 = high half.
REQ-010 Port: out_valid  output  1  result beat present.
REQ-011 Port: out_ready  input  1  consumer accepts the result beat.
REQ-012 Port: out  output  OWIDTH  selected half of sum.
REQ-013 Port: ovf  output  1  carry beyond SUMW bits for the current result beat; present only with ADDSEL_OVF_EN.

Function
REQ-014 Legal configuration SHALL satisfy WIDTH <= SUMW and OWIDTH >= 1; illegal values SHALL cause an elaboration error.
REQ-015 Sum SHALL be zero-extended a plus CONST, computed at SUMW+1 bits, truncated to SUMW bits.
REQ-016 out SHALL be sum[OWIDTH-1:0] when sel=1, sum[SUMW-1:OWIDTH] when sel=0.
REQ-017 Datapath SHALL be two register stages: S1 holds truncated sum, sel, carry; S2 holds out, ovf.
REQ-018 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput one beat per cycle.
REQ-020 S2 SHALL load when S2 empty or out_ready=1; S1 SHALL advance when S1 empty or S2 loads.
REQ-021 in_ready SHALL equal (!S1 valid) || (S2 loads this cycle), combinational from out_ready and state.
REQ-022 While out_valid=1 and out_ready=0, out and ovf SHALL hold stable and no beat SHALL be dropped or duplicated.
REQ-023 Beats SHALL emerge in acceptance order; simultaneous input and output transfer with full pipeline SHALL be legal and lossless.
REQ-024 a and sel SHALL be ignored when no input transfer occurs; empty-stage register contents are don't-care except out, which SHALL hold its last value.

Reset
REQ-025 rst_n=0 SHALL immediately clear S1 valid and S2 valid; out_valid=0 asynchronously.
REQ-026 Reset values: out=0, ovf=0, out_valid=0; in_ready=1 once rst_n=1.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; first post-reset result SHALL come from the first post-reset input transfer.

Configuration
REQ-028 Macro ADDSEL_OVF_EN defined: ovf port present, equals bit SUMW of the full-precision sum of the beat on out.
REQ-029 Macro ADDSEL_OVF_EN undefined: ovf port and carry register absent; all other behaviour identical.

Verification
REQ-030 Defaults, a=5, sel=0, out_ready=1 -> out=2'b10 two cycles later, out_valid=1 for one cycle.
REQ-031 Defaults, a=5, sel=1 then a=7, sel=1 back-to-back -> out=2'b00 then 2'b10 on consecutive cycles.
REQ-032 CONST=12, ADDSEL_OVF_EN, a=5, sel=1 -> out=2'b01, ovf=1; a=2, sel=0 -> out=2'b11, ovf=0.
REQ-033 Three beats accepted, out_ready=0 for 4 cycles -> in_ready=0 after 2 beats held, out stable, all three delivered in order after release.
REQ-034 rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale beat appears after reset release.
